fetch_unit: RTL and testbench

- Instruction fetch stage of the MIPS pipeline, directly upstream of the instruction decoder/controller.
- Holds the fetch PC and issues word requests to instruction memory over a ready/valid handshake.
- Computes the next PC from decode-stage control (PC select, jump select, branch outcome) and drives the IF/ID register (Instr_D, PC4_D, valid_D) consumed by the decoder.
- No branch delay slot: a taken redirect kills younger fetched work.

---
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, single-outstanding imem handshake,
// next-PC selection from decode control, skid buffer and IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_D,
  input  logic [1:0]  pc_sel_D,
  input  logic [1:0]  j_sel_D,
  input  logic        branch_taken_D,
  input  logic [31:0] rs_D,
  output logic [31:0] Instr_D,
  output logic [31:0] PC4_D,
  output logic        valid_D,
  output logic        redirect
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } ifid_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] pc_F;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] br_off;
  logic            kill;
  logic            buf_valid;
  ifid_t           skid;
  logic            accept;
  logic            fresh;
  logic            ifid_free;

  // Redirect is only honoured for a live D instruction that is moving on.
  always_comb begin
    redirect = 1'b0;
    if (valid_D && !stall_D) begin
      case (pc_sel_D)
        2'b10:   redirect = 1'b1;
        2'b01:   redirect = (j_sel_D != 2'b00) || branch_taken_D;
        default: redirect = 1'b0;
      endcase
    end
  end

  always_comb begin
    br_off = {{14{Instr_D[15]}}, Instr_D[15:0], 2'b00};
    if (pc_sel_D == 2'b10 || j_sel_D == 2'b11) begin
      target = rs_D & 32'hFFFF_FFFC;
    end else if (j_sel_D == 2'b00) begin
      target = PC4_D + br_off;
    end else begin
      target = {PC4_D[31:28], Instr_D[25:0], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (imem_req && imem_ready) state_nxt = WAIT;
      WAIT:    if (imem_rvalid)            state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request is held off while reset is asserted, the skid holds a word, or a redirect is pending.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_F;
    if (state == IDLE) imem_req = reset_n && !buf_valid && !redirect;
  end

  assign accept    = imem_req && imem_ready;
  assign fresh     = (state == WAIT) && imem_rvalid && !kill && !redirect;
  assign ifid_free = !valid_D || !stall_D;

  // While in WAIT, pc_F already holds the request address + 4 unless a redirect
  // moved it, and in that case the returning word is killed anyway.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_F      <= RESET_PC;
      kill      <= 1'b0;
      buf_valid <= 1'b0;
      skid      <= '0;
      valid_D   <= 1'b0;
      Instr_D   <= NOP_WORD;
      PC4_D     <= '0;
    end else begin
      if (redirect)    pc_F <= target;
      else if (accept) pc_F <= pc_F + 32'd4;

      if (state == WAIT) begin
        if (imem_rvalid)   kill <= 1'b0;
        else if (redirect) kill <= 1'b1;
      end else if (accept) begin
        kill <= 1'b0;
      end

      // IF/ID priority: redirect flush, then skid buffer, then fresh read data.
      if (redirect) begin
        valid_D   <= 1'b0;
        Instr_D   <= NOP_WORD;
        buf_valid <= 1'b0;
      end else if (ifid_free) begin
        if (buf_valid) begin
          valid_D   <= 1'b1;
          Instr_D   <= skid.instr;
          PC4_D     <= skid.pc4;
          buf_valid <= 1'b0;
        end else if (fresh) begin
          valid_D <= 1'b1;
          Instr_D <= imem_rdata;
          PC4_D   <= pc_F;
        end else if (!stall_D) begin
          valid_D <= 1'b0;
          Instr_D <= NOP_WORD;
        end
      end else if (fresh) begin
        skid.instr <= imem_rdata;
        skid.pc4   <= pc_F;
        buf_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory model answers requests and a
// scoreboard monitor checks every instruction that leaves IF/ID.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_D;
  logic [1:0]  pc_sel_D;
  logic [1:0]  j_sel_D;
  logic        branch_taken_D;
  logic [31:0] rs_D;
  logic [31:0] Instr_D;
  logic [31:0] PC4_D;
  logic        valid_D;
  logic        redirect;

  fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .stall_D        (stall_D),
    .pc_sel_D       (pc_sel_D),
    .j_sel_D        (j_sel_D),
    .branch_taken_D (branch_taken_D),
    .rs_D           (rs_D),
    .Instr_D        (Instr_D),
    .PC4_D          (PC4_D),
    .valid_D        (valid_D),
    .redirect       (redirect)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  int          total;
  int          bad;
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          lat;
  bit          last_req;
  bit          last_redirect;
  bit          redir_seen;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_3000: mem_word = 32'h3c01_1234;
      32'h0000_3004: mem_word = 32'h1000_fffe;
      32'h0000_300c: mem_word = 32'h0c00_0c10;
      default:       mem_word = {16'h2400, a[15:0]};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_req(input int idx, input logic [31:0] exp);
    total++;
    if (idx >= req_log.size()) begin
      bad++;
      $display("FAIL req_addr[%0d] actual=none required=%h", idx, exp);
    end else if (req_log[idx] !== exp) begin
      bad++;
      $display("FAIL req_addr[%0d] actual=%h required=%h", idx, req_log[idx], exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc4);
    exp_t e;
    e.instr = instr;
    e.pc4   = pc4;
    exp_q.push_back(e);
  endtask

  // One clock cycle, entered and left at a falling edge; models the memory.
  task automatic tick();
    if (pend && pend_cnt <= 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr);
      pend        = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (pend) pend_cnt--;
    end
    #1;
    last_req      = imem_req;
    last_redirect = redirect;
    if (redirect) redir_seen = 1'b1;
    if (imem_req && imem_ready) begin
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_addr = imem_addr;
      req_log.push_back(imem_addr);
    end
    @(negedge clk);
  endtask

  task automatic wait_d(input logic [31:0] pc4);
    int n;
    n = 0;
    while (!(valid_D && PC4_D == pc4) && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL wait_d actual=timeout required=PC4_D %h", pc4);
    end
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    stall_D        = 1'b0;
    pc_sel_D       = 2'b00;
    j_sel_D        = 2'b00;
    branch_taken_D = 1'b0;
    rs_D           = 32'h0;
    imem_ready     = 1'b1;
    lat            = 1;
    pend           = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    req_log.delete();
    redir_seen = 1'b0;
  endtask

  task automatic drain();
    imem_ready = 1'b0;
    stall_D    = 1'b0;
    pc_sel_D   = 2'b00;
    tick();
    tick();
    tick();
  endtask

  // Scoreboard monitor: an instruction retires from IF/ID when valid and not stalled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && valid_D && !stall_D) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL ifid_extra actual=%h/%h required=none", Instr_D, PC4_D);
        end else begin
          e = exp_q.pop_front();
          if (Instr_D !== e.instr || PC4_D !== e.pc4) begin
            bad++;
            $display("FAIL ifid actual=%h/%h required=%h/%h", Instr_D, PC4_D, e.instr, e.pc4);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    imem_ready  = 1'b1;
    stall_D = 1'b0; pc_sel_D = 2'b00; j_sel_D = 2'b00; branch_taken_D = 1'b0; rs_D = 32'h0;
    pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0; lat = 1;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("rst_valid",    {31'h0, valid_D},  32'h0);
    check("rst_instr",    Instr_D,           32'h0);
    check("rst_pc4",      PC4_D,             32'h0);
    check("rst_req",      {31'h0, imem_req}, 32'h0);
    check("rst_redirect", {31'h0, redirect}, 32'h0);
    @(negedge clk);

    // Sequential fetch, branch never taken.
    do_reset();
    pc_sel_D = 2'b01;
    push_exp(32'h3c01_1234, 32'h0000_3004);
    push_exp(32'h1000_fffe, 32'h0000_3008);
    push_exp(32'h2400_3008, 32'h0000_300c);
    push_exp(32'h0c00_0c10, 32'h0000_3010);
    tick();
    check("first_addr", imem_addr - 32'd4, 32'h0000_3000);
    wait_d(32'h0000_3010);
    drain();
    check_req(0, 32'h0000_3000);
    check_req(1, 32'h0000_3004);
    check_req(2, 32'h0000_3008);
    check_req(3, 32'h0000_300c);
    check("seq_req_count", 32'(req_log.size()), 32'd4);
    check("seq_no_redirect", {31'h0, redir_seen}, 32'h0);

    // Taken beq with a word in flight, then jal and jr.
    do_reset();
    push_exp(32'h3c01_1234, 32'h0000_3004);
    push_exp(32'h1000_fffe, 32'h0000_3008);
    push_exp(32'h3c01_1234, 32'h0000_3004);
    push_exp(32'h1000_fffe, 32'h0000_3008);
    push_exp(32'h2400_3008, 32'h0000_300c);
    push_exp(32'h0c00_0c10, 32'h0000_3010);
    push_exp(32'h2400_3040, 32'h0000_3044);
    push_exp(32'h2400_3024, 32'h0000_3028);
    wait_d(32'h0000_3008);
    stall_D = 1'b1;
    lat = 2;
    tick();
    stall_D = 1'b0; pc_sel_D = 2'b01; j_sel_D = 2'b00; branch_taken_D = 1'b1; lat = 1;
    tick();
    check("beq_redirect", {31'h0, last_redirect}, 32'h1);
    pc_sel_D = 2'b00; branch_taken_D = 1'b0;
    tick();
    check("beq_killed_valid", {31'h0, valid_D}, 32'h0);
    wait_d(32'h0000_3010);
    pc_sel_D = 2'b01; j_sel_D = 2'b10;
    tick();
    check("jal_redirect", {31'h0, last_redirect}, 32'h1);
    check("jal_no_req",   {31'h0, last_req},      32'h0);
    pc_sel_D = 2'b00; j_sel_D = 2'b00;
    wait_d(32'h0000_3044);
    pc_sel_D = 2'b10; rs_D = 32'h0000_3027;
    tick();
    check("jr_redirect", {31'h0, last_redirect}, 32'h1);
    pc_sel_D = 2'b00;
    wait_d(32'h0000_3028);
    drain();
    check_req(2, 32'h0000_3008);
    check_req(3, 32'h0000_3000);
    check_req(6, 32'h0000_300c);
    check_req(7, 32'h0000_3040);
    check_req(8, 32'h0000_3024);
    check("redir_req_count", 32'(req_log.size()), 32'd9);

    // Stall while the next word returns: skid buffer absorbs it.
    do_reset();
    push_exp(32'h3c01_1234, 32'h0000_3004);
    push_exp(32'h1000_fffe, 32'h0000_3008);
    push_exp(32'h2400_3008, 32'h0000_300c);
    wait_d(32'h0000_3004);
    stall_D = 1'b1;
    tick();
    tick();
    tick();
    check("stall_req_held", {31'h0, last_req}, 32'h0);
    check("stall_d_held", PC4_D, 32'h0000_3004);
    stall_D = 1'b0;
    tick();
    check("skid_drain_no_req", {31'h0, last_req}, 32'h0);
    wait_d(32'h0000_300c);
    drain();
    check_req(1, 32'h0000_3004);
    check_req(2, 32'h0000_3008);
    check("stall_req_count", 32'(req_log.size()), 32'd3);

    // Reset while a request is outstanding; the late response must be ignored.
    do_reset();
    push_exp(32'h3c01_1234, 32'h0000_3004);
    lat = 3;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    check("midrst_valid", {31'h0, valid_D},  32'h0);
    check("midrst_req",   {31'h0, imem_req}, 32'h0);
    reset_n = 1'b1;
    lat = 1;
    tick();
    check("late_rvalid_ignored", {31'h0, valid_D}, 32'h0);
    tick();
    wait_d(32'h0000_3004);
    drain();
    check_req(0, 32'h0000_3000);
    check_req(1, 32'h0000_3000);
    check("rst_req_count", 32'(req_log.size()), 32'd2);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
